// File: rtl/rx_frame_sync_pkg.sv
// rx_frame_sync_pkg
// Shared types and constants for the RX byte framer that sits between the
// UART RX FIFO and the 8-to-24 RGB packer of the Sobel pipeline.
//   frame_state_e : framer FSM states
//   SYNC*_DEF     : default two-byte sync header
//   rgb_bytes()   : byte count of an RGB888 region (pixels/line x lines x 3)
//   cnt_width()   : width of a counter able to index the larger region
package rx_frame_sync_pkg;

  typedef enum logic [1:0] {
    HUNT0 = 2'd0,
    HUNT1 = 2'd1,
    PASS  = 2'd2,
    FLUSH = 2'd3
  } frame_state_e;

  localparam logic [7:0] SYNC0_DEF = 8'hA5;
  localparam logic [7:0] SYNC1_DEF = 8'h5A;

  function automatic int rgb_bytes(input int pixels_per_line, input int lines);
    return 3 * pixels_per_line * lines;
  endfunction

  function automatic int cnt_width(input int pay_bytes, input int pad_bytes);
    return $clog2(((pay_bytes > pad_bytes) ? pay_bytes : pad_bytes) + 1);
  endfunction

endpackage

// File: rtl/rx_frame_sync_elastic.sv
// rx_frame_sync_elastic
// One-entry registered elastic buffer. A word loaded while the buffer can
// accept is presented on the next cycle and held until the consumer takes it.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   load_i, data_i : producer write strobe and word (only honoured when
//                    can_accept_o is high)
//   can_accept_o   : buffer empty, or its word leaves this cycle
//   valid_o,data_o : registered output word
//   ready_i        : consumer takes data_o this cycle when valid_o is high
module rx_frame_sync_elastic
  import rx_frame_sync_pkg::*;
#(
  parameter int WIDTH_P = 9
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [WIDTH_P-1:0] data_i,
  output logic               can_accept_o,
  output logic               valid_o,
  output logic [WIDTH_P-1:0] data_o,
  input  logic               ready_i
);

  logic               valid_q, valid_d;
  logic [WIDTH_P-1:0] data_q,  data_d;

  assign can_accept_o = ~valid_q | ready_i;

  // A load during an unload replaces the word and keeps valid high.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i && can_accept_o) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/rx_frame_sync.sv
// rx_frame_sync
// Hunts for the two-byte sync header in the RX byte stream, strips it,
// forwards one frame of RGB payload bytes (first one tagged with sof_o), then
// injects zero pad lines so the Sobel line buffers drain the last rows.
// Ports:
//   clk_i, rst_i             : clock, synchronous active-high reset
//   data_i, valid_i, ready_o : byte stream from the RX FIFO
//   data_o, valid_o, ready_i : byte stream to the RGB packer (registered)
//   sof_o                    : tags the first payload byte of a frame
//   busy_o                   : framer not idle-hunting or output pending
//   sync_err_o               : one-cycle pulse on a bad second header byte
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   HUNT0 | discard bytes, waiting for SYNC0
//   HUNT1 | SYNC0 seen, expecting SYNC1 (repeated SYNC0 keeps waiting)
//   PASS  | forward PAY_BYTES payload bytes through the output buffer
//   FLUSH | input stalled, emit PAD_BYTES zero bytes
module rx_frame_sync
  import rx_frame_sync_pkg::*;
#(
  parameter int         LINE_W_P    = 640,
  parameter int         FRAME_H_P   = 480,
  parameter int         PAD_LINES_P = 4,
  parameter logic [7:0] SYNC0_P     = SYNC0_DEF,
  parameter logic [7:0] SYNC1_P     = SYNC1_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       sof_o,
  output logic       busy_o,
  output logic       sync_err_o
);

  localparam int PAY_BYTES = rgb_bytes(LINE_W_P, FRAME_H_P);
  localparam int PAD_BYTES = rgb_bytes(LINE_W_P, PAD_LINES_P);
  localparam int CNT_W     = cnt_width(PAY_BYTES, PAD_BYTES);

  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAY_BYTES - 1);
  localparam logic [CNT_W-1:0] PAD_LAST = CNT_W'(PAD_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  frame_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             sync_err_q, sync_err_d;

  logic             buf_can_accept;
  logic             buf_load;
  logic [8:0]       buf_din;
  logic [8:0]       buf_dout;
  logic             buf_valid;
  logic             in_fire;

  // Hold off the FIFO during reset so no byte is popped and then discarded.
  always_comb begin
    ready_o = 1'b0;
    unique case (state_q)
      HUNT0, HUNT1: ready_o = 1'b1;
      PASS:         ready_o = buf_can_accept;
      FLUSH:        ready_o = 1'b0;
      default:      ready_o = 1'b0;
    endcase
    if (rst_i) begin
      ready_o = 1'b0;
    end
  end

  assign in_fire = valid_i & ready_o;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sync_err_d = 1'b0;
    buf_load   = 1'b0;
    buf_din    = '0;
    unique case (state_q)
      HUNT0: begin
        if (in_fire && (data_i == SYNC0_P)) begin
          state_d = HUNT1;
        end
      end
      HUNT1: begin
        if (in_fire) begin
          if (data_i == SYNC1_P) begin
            state_d = PASS;
            cnt_d   = '0;
          end else if (data_i != SYNC0_P) begin
            state_d    = HUNT0;
            sync_err_d = 1'b1;
          end
        end
      end
      PASS: begin
        // Header bytes inside the payload are plain data here.
        if (in_fire) begin
          buf_load = 1'b1;
          buf_din  = {(cnt_q == '0), data_i};
          if (cnt_q == PAY_LAST) begin
            state_d = FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      FLUSH: begin
        // The last pad byte may still sit in the buffer after HUNT0 is
        // entered; it drains while the next header is hunted.
        if (buf_can_accept) begin
          buf_load = 1'b1;
          buf_din  = 9'h000;
          if (cnt_q == PAD_LAST) begin
            state_d = HUNT0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d = HUNT0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= HUNT0;
      cnt_q      <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync_err_q <= sync_err_d;
    end
  end

  rx_frame_sync_elastic #(
    .WIDTH_P (9)
  ) u_out_buf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (buf_load),
    .data_i       (buf_din),
    .can_accept_o (buf_can_accept),
    .valid_o      (buf_valid),
    .data_o       (buf_dout),
    .ready_i      (ready_i)
  );

  assign valid_o    = buf_valid;
  assign data_o     = buf_dout[7:0];
  assign sof_o      = buf_dout[8];
  assign busy_o     = (state_q != HUNT0) | buf_valid;
  assign sync_err_o = sync_err_q;

endmodule

// File: tb/tb_rx_frame_sync.sv
module tb_rx_frame_sync;

  localparam int LW  = 4;
  localparam int FH  = 2;
  localparam int PL  = 1;
  localparam int PAY = 3 * LW * FH;
  localparam int PAD = 3 * LW * PL;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic       sof_o;
  logic       busy_o;
  logic       sync_err_o;

  always #5 clk_i = ~clk_i;

  rx_frame_sync #(
    .LINE_W_P    (LW),
    .FRAME_H_P   (FH),
    .PAD_LINES_P (PL),
    .SYNC0_P     (8'hA5),
    .SYNC1_P     (8'h5A)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .sof_o      (sof_o),
    .busy_o     (busy_o),
    .sync_err_o (sync_err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] exp_q[$];
  logic [7:0] stim_q[$];
  int exp_err   = 0;
  int err_seen  = 0;
  int out_count = 0;
  int ready_mode = 0;   // 0: always ready, 1: random 50%, 2: held low

  // reference model: 0 = hunting, 1 = first header byte seen, 2 = in payload
  int m_mode = 0;
  int m_idx  = 0;

  logic       prev_stall = 1'b0;
  logic [8:0] prev_word  = 9'h000;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_accept(input logic [7:0] b);
    case (m_mode)
      0: if (b == 8'hA5) m_mode = 1;
      1: begin
        if (b == 8'h5A) begin
          m_mode = 2;
          m_idx  = 0;
        end else if (b != 8'hA5) begin
          m_mode = 0;
          exp_err++;
        end
      end
      default: begin
        exp_q.push_back({(m_idx == 0), b});
        m_idx++;
        if (m_idx == PAY) begin
          for (int k = 0; k < PAD; k++) exp_q.push_back(9'h000);
          m_mode = 0;
        end
      end
    endcase
  endtask

  // ready_i changes just after the active edge
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = ($urandom_range(1, 0) == 1);
        default: ready_i = 1'b0;
      endcase
    end
  end

  // monitor: samples 1 time unit before the active edge
  initial begin
    logic [8:0] exp_w;
    forever begin
      @(negedge clk_i);
      #4;
      if (rst_i) begin
        prev_stall = 1'b0;
      end else begin
        if (sync_err_o) err_seen++;
        if (prev_stall) begin
          check("stall_valid", int'(valid_o), 1);
          check("stall_sof_data", int'({sof_o, data_o}), int'(prev_word));
        end
        if (valid_o && ready_i) begin
          out_count++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out: got %0h with nothing expected (t=%0t)", {sof_o, data_o}, $time);
          end else begin
            exp_w = exp_q.pop_front();
            check("out_sof_data", int'({sof_o, data_o}), int'(exp_w));
          end
        end
        prev_stall = valid_o && !ready_i;
        prev_word  = {sof_o, data_o};
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard;
    if (gaps) begin
      int g;
      g = $urandom_range(2, 0);
      if (g > 0) begin
        valid_i = 1'b0;
        repeat (g) @(negedge clk_i);
      end
    end
    data_i  = b;
    valid_i = 1'b1;
    guard   = 0;
    forever begin
      #4;
      if (ready_o) begin
        model_accept(b);
        @(negedge clk_i);
        valid_i = 1'b0;
        break;
      end
      @(negedge clk_i);
      guard++;
      if (guard > 1000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: byte %0h not accepted after %0d cycles", b, guard);
        valid_i = 1'b0;
        break;
      end
    end
  endtask

  task automatic send_stim(input bit gaps);
    while (stim_q.size() != 0) send_byte(stim_q.pop_front(), gaps);
    valid_i = 1'b0;
  endtask

  // kind 0: 1..24, kind 1: 1..24 with A5 5A at bytes 3-4, kind 2: random
  task automatic add_payload(input int kind);
    for (int i = 0; i < PAY; i++) begin
      logic [7:0] b;
      b = 8'(i + 1);
      if (kind == 1 && i == 2) b = 8'hA5;
      if (kind == 1 && i == 3) b = 8'h5A;
      if (kind == 2) b = 8'($urandom_range(255, 0));
      stim_q.push_back(b);
    end
  endtask

  task automatic add_header();
    stim_q.push_back(8'hA5);
    stim_q.push_back(8'h5A);
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk_i);
      guard++;
    end
    repeat (5) @(negedge clk_i);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_sync_err"}, err_seen, exp_err);
  endtask

  initial begin
    logic [8:0] held;

    // reset state
    repeat (3) @(negedge clk_i);
    #4;
    check("rst_valid", int'(valid_o), 0);
    check("rst_data", int'(data_o), 0);
    check("rst_sof", int'(sof_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_sync_err", int'(sync_err_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #4;
    check("post_rst_ready", int'(ready_o), 1);
    @(negedge clk_i);

    // basic frame, with flush timing
    out_count = 0;
    add_header();
    add_payload(0);
    send_stim(1'b0);
    for (int i = 1; i <= PAD; i++) begin
      #4;
      check("flush_ready_low", int'(ready_o), 0);
      @(negedge clk_i);
    end
    #4;
    check("hunt_ready_high", int'(ready_o), 1);
    check("last_pad_valid", int'(valid_o), 1);
    check("last_pad_busy", int'(busy_o), 1);
    @(negedge clk_i);
    #4;
    check("busy_fall", int'(busy_o), 0);
    @(negedge clk_i);
    drain("basic");
    check("basic_count", out_count, PAY + PAD);

    // garbage prefix with repeated A5
    out_count = 0;
    stim_q.push_back(8'h33);
    stim_q.push_back(8'hA5);
    add_header();
    add_payload(0);
    send_stim(1'b0);
    drain("garbage");
    check("garbage_count", out_count, PAY + PAD);

    // bad header, then a good frame
    out_count = 0;
    stim_q.push_back(8'hA5);
    stim_q.push_back(8'h77);
    send_stim(1'b0);
    repeat (2) @(negedge clk_i);
    #4;
    check("bad_hdr_err", err_seen, 1);
    check("bad_hdr_busy", int'(busy_o), 0);
    check("bad_hdr_no_out", out_count, 0);
    @(negedge clk_i);
    add_header();
    add_payload(0);
    send_stim(1'b0);
    drain("bad_hdr");
    check("bad_hdr_count", out_count, PAY + PAD);

    // header pattern inside payload
    out_count = 0;
    add_header();
    add_payload(1);
    send_stim(1'b0);
    drain("embedded");
    check("embedded_count", out_count, PAY + PAD);

    // random back-pressure and input gaps over three frames
    out_count  = 0;
    ready_mode = 1;
    for (int f = 0; f < 3; f++) begin
      add_header();
      add_payload(2);
    end
    send_stim(1'b1);
    drain("random");
    check("random_count", out_count, 3 * (PAY + PAD));
    ready_mode = 0;
    repeat (2) @(negedge clk_i);

    // reset mid-frame with a byte held in the output buffer
    add_header();
    for (int i = 0; i < 9; i++) stim_q.push_back(8'(i + 1));
    send_stim(1'b0);
    ready_mode = 2;
    send_byte(8'h0A, 1'b0);
    #1;
    check("pre_rst_valid", int'(valid_o), 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    #4;
    check("mid_rst_valid", int'(valid_o), 0);
    check("mid_rst_busy", int'(busy_o), 0);
    check("mid_rst_ready", int'(ready_o), 1);
    check("mid_rst_pending", exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      held = exp_q.pop_front();
      check("mid_rst_held_byte", int'(held), 9'h00A);
    end
    exp_q.delete();
    m_mode = 0;
    m_idx  = 0;
    ready_mode = 0;
    @(negedge clk_i);
    out_count = 0;
    add_header();
    add_payload(2);
    send_stim(1'b0);
    drain("after_rst");
    check("after_rst_count", out_count, PAY + PAD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
